// File: rtl/vga_frame_driver_pkg.sv
// Shared state codes, colours, timing defaults and grid constants
// for the VGA frame driver slice.
package vga_frame_driver_pkg;

    typedef enum logic [2:0] {
        MAIN_IDLE  = 3'd0,
        MAIN_START = 3'd1,
        MAIN_PLAY1 = 3'd2,
        MAIN_PLAY2 = 3'd3,
        MAIN_PLAY3 = 3'd4,
        MAIN_DEAD  = 3'd5,
        MAIN_WIN   = 3'd6
    } main_state_t;

    localparam logic [11:0] RGB_BLACK    = 12'h000;
    localparam logic [11:0] RGB_WHITE    = 12'hFFF;
    localparam logic [11:0] RGB_RED      = 12'hF00;
    localparam logic [11:0] RGB_GOLD     = 12'hFC0;
    localparam logic [11:0] RGB_MARGIN   = 12'h888;
    localparam logic [11:0] RGB_OBSTACLE = 12'h840;
    localparam logic [11:0] RGB_SNAKE    = 12'h0F0;
    localparam logic [11:0] RGB_POISON   = 12'hF0F;
    localparam logic [11:0] RGB_FLASH    = 12'hFF0;
    localparam logic [11:0] RGB_VIRUS    = 12'h80F;
    localparam logic [11:0] RGB_GRID     = 12'h222;

    localparam int H_ACTIVE_DEF  = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;
    localparam int TICK_DIV_DEF  = 2;
    localparam int BLINK_BIT_DEF = 4;

    localparam int GRID_CELL = 16;
    localparam int GRID_COLS = H_ACTIVE_DEF / GRID_CELL;
    localparam int GRID_ROWS = V_ACTIVE_DEF / GRID_CELL;

    // True when pos lies in [lo, lo+len)
    function automatic logic in_window(
        input logic [9:0] pos,
        input int         lo,
        input int         len
    );
        return (pos >= 10'(lo)) && (pos < 10'(lo + len));
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel divider, h/v scan counters, frame strobe and raw
// sync/visible decode for the current scan position.
module vga_sync_counter
    import vga_frame_driver_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic       clk_crystal,
    input  logic       rst_global,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_tick,
    output logic       frame_tick,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       visible_raw
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             line_end;
    logic             frame_end;

    assign pixel_tick = (div_cnt == DIV_LAST);
    assign line_end   = (pixel_x == 10'(H_TOTAL - 1));
    assign frame_end  = (pixel_y == 10'(V_TOTAL - 1));

    // Divide the crystal clock down to the pixel rate
    always_ff @(posedge clk_crystal) begin
        if (!rst_global) begin
            div_cnt <= '0;
        end else if (pixel_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Scan counters advance once per pixel; frame strobe follows the wrap
    always_ff @(posedge clk_crystal) begin
        if (!rst_global) begin
            pixel_x    <= '0;
            pixel_y    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pixel_tick && line_end && frame_end;
            if (pixel_tick) begin
                if (line_end) begin
                    pixel_x <= '0;
                    pixel_y <= frame_end ? '0 : pixel_y + 10'd1;
                end else begin
                    pixel_x <= pixel_x + 10'd1;
                end
            end
        end
    end

    assign hsync_raw   = !in_window(pixel_x, H_ACTIVE + H_FP, H_SYNC);
    assign vsync_raw   = !in_window(pixel_y, V_ACTIVE + V_FP, V_SYNC);
    assign visible_raw = (pixel_x < 10'(H_ACTIVE)) &&
                         (pixel_y < 10'(V_ACTIVE));

endmodule

// File: rtl/vga_frame_driver.sv
// VGA frame driver: scan timing out, region flags in, registered
// RGB and syncs out, all lagging the scan counters by one pixel.
module vga_frame_driver
    import vga_frame_driver_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int BLINK_BIT = BLINK_BIT_DEF
) (
    input  logic       clk_crystal,
    input  logic       rst_global,
    input  logic [2:0] state,
    input  logic       map_region,
    input  logic       margin,
    input  logic       grid_line,
    input  logic       obstacle_region,
    input  logic       snake_region,
    input  logic       food_region,
    input  logic       food_shape_region,
    input  logic       flash_region,
    input  logic       flash_shape_region,
    input  logic       virus_region,
    input  logic       virus_shape_region,
    input  logic       start_region,
    input  logic       dead_region,
    input  logic       win_region,
    input  logic       poisoning,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_tick,
    output logic       frame_tick,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    logic        hsync_raw;
    logic        vsync_raw;
    logic        visible_raw;
    logic [7:0]  frame_cnt;
    logic        blink;
    logic [11:0] play_colour;
    logic [11:0] colour;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .TICK_DIV (TICK_DIV)
    ) u_sync (
        .clk_crystal (clk_crystal),
        .rst_global  (rst_global),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_tick  (pixel_tick),
        .frame_tick  (frame_tick),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .visible_raw (visible_raw)
    );

    // Frame counter drives the poison blink phase
    always_ff @(posedge clk_crystal) begin
        if (!rst_global) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign blink = frame_cnt[BLINK_BIT];

    // In-game layering, highest priority first
    always_comb begin
        play_colour = RGB_BLACK;
        if (!map_region) begin
            play_colour = RGB_BLACK;
        end else if (margin) begin
            play_colour = RGB_MARGIN;
        end else if (obstacle_region) begin
            play_colour = RGB_OBSTACLE;
        end else if (snake_region) begin
            play_colour = (poisoning && blink) ? RGB_POISON : RGB_SNAKE;
        end else if (food_region && food_shape_region) begin
            play_colour = RGB_RED;
        end else if (flash_region && flash_shape_region) begin
            play_colour = RGB_FLASH;
        end else if (virus_region && virus_shape_region) begin
            play_colour = RGB_VIRUS;
        end else if (grid_line) begin
            play_colour = RGB_GRID;
        end
    end

    // Pick the screen's colour source from the game state
    always_comb begin
        colour = RGB_BLACK;
        case (main_state_t'(state))
            MAIN_START: colour = start_region ? RGB_WHITE : RGB_BLACK;
            MAIN_DEAD:  colour = dead_region  ? RGB_RED   : RGB_BLACK;
            MAIN_WIN:   colour = win_region   ? RGB_GOLD  : RGB_BLACK;
            MAIN_PLAY1,
            MAIN_PLAY2,
            MAIN_PLAY3: colour = play_colour;
            default:    colour = RGB_BLACK;
        endcase
    end

    // Register colour and syncs together on the pixel strobe
    always_ff @(posedge clk_crystal) begin
        if (!rst_global) begin
            video_on            <= 1'b0;
            hsync               <= 1'b1;
            vsync               <= 1'b1;
            {vga_r, vga_g, vga_b} <= RGB_BLACK;
        end else if (pixel_tick) begin
            video_on            <= visible_raw;
            hsync               <= hsync_raw;
            vsync               <= vsync_raw;
            {vga_r, vga_g, vga_b} <= visible_raw ? colour : RGB_BLACK;
        end
    end

endmodule

// File: tb/tb_vga_frame_driver.sv
// Scoreboard bench for vga_frame_driver on a shrunken raster so
// many whole frames fit in a short run.
module tb_vga_frame_driver;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int TD = 2,  BB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT * TD;

    localparam logic [14:0] M_MAP     = 15'h4000;
    localparam logic [14:0] M_MARGIN  = 15'h2000;
    localparam logic [14:0] M_GRID    = 15'h1000;
    localparam logic [14:0] M_OBST    = 15'h0800;
    localparam logic [14:0] M_SNAKE   = 15'h0400;
    localparam logic [14:0] M_FOOD    = 15'h0200;
    localparam logic [14:0] M_FSHAPE  = 15'h0100;
    localparam logic [14:0] M_FLASH   = 15'h0080;
    localparam logic [14:0] M_FLSHAPE = 15'h0040;
    localparam logic [14:0] M_VIRUS   = 15'h0020;
    localparam logic [14:0] M_VSHAPE  = 15'h0010;
    localparam logic [14:0] M_START   = 15'h0008;
    localparam logic [14:0] M_DEAD    = 15'h0004;
    localparam logic [14:0] M_WIN     = 15'h0002;
    localparam logic [14:0] M_POISON  = 15'h0001;

    localparam int MODE_RAND = 0, MODE_DIR = 1, MODE_BLINK = 2;

    logic       clk_crystal = 1'b0;
    logic       rst_global;
    logic [2:0] st;
    logic [14:0] fl;
    logic       map_region, margin, grid_line, obstacle_region;
    logic       snake_region, food_region, food_shape_region;
    logic       flash_region, flash_shape_region;
    logic       virus_region, virus_shape_region;
    logic       start_region, dead_region, win_region, poisoning;
    logic [9:0] pixel_x, pixel_y;
    logic       pixel_tick, frame_tick, video_on, hsync, vsync;
    logic [3:0] vga_r, vga_g, vga_b;

    assign {map_region, margin, grid_line, obstacle_region, snake_region,
            food_region, food_shape_region, flash_region,
            flash_shape_region, virus_region, virus_shape_region,
            start_region, dead_region, win_region, poisoning} = fl;

    vga_frame_driver #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .TICK_DIV (TD), .BLINK_BIT (BB)
    ) dut (
        .clk_crystal        (clk_crystal),
        .rst_global         (rst_global),
        .state              (st),
        .map_region         (map_region),
        .margin             (margin),
        .grid_line          (grid_line),
        .obstacle_region    (obstacle_region),
        .snake_region       (snake_region),
        .food_region        (food_region),
        .food_shape_region  (food_shape_region),
        .flash_region       (flash_region),
        .flash_shape_region (flash_shape_region),
        .virus_region       (virus_region),
        .virus_shape_region (virus_shape_region),
        .start_region       (start_region),
        .dead_region        (dead_region),
        .win_region         (win_region),
        .poisoning          (poisoning),
        .pixel_x            (pixel_x),
        .pixel_y            (pixel_y),
        .pixel_tick         (pixel_tick),
        .frame_tick         (frame_tick),
        .video_on           (video_on),
        .hsync              (hsync),
        .vsync              (vsync),
        .vga_r              (vga_r),
        .vga_g              (vga_g),
        .vga_b              (vga_b)
    );

    always #5 clk_crystal = ~clk_crystal;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc, mx, my, mode, dir_i;
    logic [7:0]  mframe;
    logic        ft_pend, ft_first, ft_seen;
    logic [11:0] dir_rgb;
    logic [14:0] q[$];

    logic [2:0]  tbl_st[15];
    logic [14:0] tbl_fl[15];
    logic [11:0] tbl_rgb[15];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d)",
                     tag, got, exp, mx, my);
        end
    endtask

    function automatic logic [11:0] ref_colour(input logic [2:0] s,
                                               input logic [14:0] f,
                                               input logic bl);
        logic [11:0] c;
        c = 12'h000;
        case (s)
            3'd1: c = |(f & M_START) ? 12'hFFF : 12'h000;
            3'd5: c = |(f & M_DEAD)  ? 12'hF00 : 12'h000;
            3'd6: c = |(f & M_WIN)   ? 12'hFC0 : 12'h000;
            3'd2, 3'd3, 3'd4: begin
                if (!(|(f & M_MAP)))            c = 12'h000;
                else if (|(f & M_MARGIN))       c = 12'h888;
                else if (|(f & M_OBST))         c = 12'h840;
                else if (|(f & M_SNAKE))
                    c = (|(f & M_POISON) && bl) ? 12'hF0F : 12'h0F0;
                else if ((f & (M_FOOD | M_FSHAPE)) == (M_FOOD | M_FSHAPE))
                    c = 12'hF00;
                else if ((f & (M_FLASH | M_FLSHAPE)) == (M_FLASH | M_FLSHAPE))
                    c = 12'hFF0;
                else if ((f & (M_VIRUS | M_VSHAPE)) == (M_VIRUS | M_VSHAPE))
                    c = 12'h80F;
                else if (|(f & M_GRID))         c = 12'h222;
                else                            c = 12'h000;
            end
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    task automatic drive_inputs();
        int k;
        case (mode)
            MODE_DIR: begin
                k = dir_i % 15;
                st = tbl_st[k];
                fl = tbl_fl[k];
                dir_rgb = tbl_rgb[k];
                dir_i++;
            end
            MODE_BLINK: begin
                st = 3'd2;
                fl = M_MAP | M_SNAKE | M_POISON;
            end
            default: begin
                st = 3'($urandom_range(7, 0));
                fl = 15'($urandom);
                if ($urandom_range(3, 0) != 0) fl = fl | M_MAP;
            end
        endcase
    endtask

    function automatic logic [14:0] expect_out();
        logic        vis, hs, vs;
        logic [11:0] c;
        vis = (mx < HA) && (my < VA);
        hs  = !((mx >= HA + HF) && (mx < HA + HF + HS));
        vs  = !((my >= VA + VF) && (my < VA + VF + VS));
        if (mode == MODE_DIR) c = dir_rgb;
        else c = ref_colour(st, fl, mframe[BB]);
        if (!vis) c = 12'h000;
        return {vis, hs, vs, c};
    endfunction

    task automatic cycle();
        logic        tick_e;
        logic [14:0] e;
        @(negedge clk_crystal);
        if (!rst_global) begin
            check("reset_outputs",
                  64'({pixel_x, pixel_y, pixel_tick, frame_tick, video_on,
                       hsync, vsync, vga_r, vga_g, vga_b}),
                  64'({20'd0, 3'b000, 2'b11, 12'h000}));
            cyc = 0; mx = 0; my = 0; mframe = '0;
            ft_pend = 1'b0; ft_first = 1'b1; ft_seen = 1'b0;
            q.delete();
        end else begin
            cyc++;
            tick_e = (cyc % TD) == (TD - 1);
            check("pixel_tick", 64'(pixel_tick), 64'(tick_e));
            if (ft_pend || frame_tick)
                check("frame_tick", 64'(frame_tick), 64'(ft_pend));
            if (frame_tick && ft_first) begin
                check("first_frame_cycle", 64'(cyc), 64'(FRAME));
                ft_first = 1'b0;
                ft_seen = 1'b1;
            end
            ft_pend = 1'b0;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pixel_out",
                      64'({video_on, hsync, vsync, vga_r, vga_g, vga_b}),
                      64'(e));
            end
            if (tick_e) begin
                check("scan_pos", 64'({pixel_x, pixel_y}),
                      64'({10'(mx), 10'(my)}));
                drive_inputs();
                q.push_back(expect_out());
                if (mx == HT - 1) begin
                    mx = 0;
                    if (my == VT - 1) begin
                        my = 0;
                        ft_pend = 1'b1;
                        mframe = mframe + 8'd1;
                    end else begin
                        my++;
                    end
                end else begin
                    mx++;
                end
            end
        end
    endtask

    initial begin
        tbl_st  = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4,
                    3'd1, 3'd5, 3'd6, 3'd0, 3'd7, 3'd2, 3'd5};
        tbl_fl  = '{M_MAP | M_MARGIN | M_SNAKE,
                    M_MAP | M_SNAKE,
                    M_MAP | M_FOOD | M_FSHAPE,
                    M_MAP | M_OBST | M_SNAKE | M_GRID,
                    M_MAP | M_FLASH | M_FLSHAPE | M_GRID,
                    M_MAP | M_VIRUS | M_VSHAPE | M_GRID,
                    M_MAP | M_GRID | M_FOOD,
                    M_MARGIN | M_SNAKE,
                    M_START,
                    M_DEAD,
                    M_WIN,
                    15'h7FFE,
                    15'h7FFE,
                    M_MAP | M_FOOD | M_FSHAPE | M_FLASH | M_FLSHAPE,
                    M_START | M_WIN};
        tbl_rgb = '{12'h888, 12'h0F0, 12'hF00, 12'h840, 12'hFF0,
                    12'h80F, 12'h222, 12'h000, 12'hFFF, 12'hF00,
                    12'hFC0, 12'h000, 12'h000, 12'hF00, 12'h000};
        st = 3'd0; fl = '0; mode = MODE_RAND; dir_i = 0;
        cyc = 0; mx = 0; my = 0; mframe = '0;
        ft_pend = 1'b0; ft_first = 1'b1; ft_seen = 1'b0;
        dir_rgb = '0;
        rst_global = 1'b0;
        repeat (3) cycle();
        rst_global = 1'b1;

        mode = MODE_RAND;
        repeat (2 * FRAME) cycle();
        mode = MODE_DIR;
        repeat (2 * FRAME) cycle();
        mode = MODE_BLINK;
        repeat (33 * FRAME) cycle();

        mode = MODE_RAND;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (mx == 11 && my == 3) break;
            cycle();
        end
        rst_global = 1'b0;
        repeat (3) cycle();
        rst_global = 1'b1;
        repeat (FRAME + 8) cycle();
        check("frame_after_reset_seen", 64'(ft_seen), 64'(1));
        repeat (FRAME) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
